// File: rtl/debug_slave_hub.sv
// debug_slave_hub: one JTAG-style command port (strobes already in the clk
// domain) shared by NUM_CORES debug slaves. Handles capture, LSB-first DR
// shift and update decode. An update raises one per-core, per-instruction
// take_action request, which is held until that core acknowledges it or the
// optional ack timeout expires.
module debug_slave_hub #(
  parameter int NUM_CORES   = 4,
  parameter int DR_W        = 38,
  parameter int IR_W        = 2,
  parameter int ACK_TIMEOUT = 255,
  localparam int CSEL_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            vs_uir,
  input  logic                            vs_cdr,
  input  logic                            vs_sdr,
  input  logic                            vs_udr,
  input  logic [CSEL_W+IR_W-1:0]          ir_in,
  input  logic                            tdi,
  output logic                            tdo,
  input  logic [NUM_CORES*DR_W-1:0]       capture_data,
  input  logic [NUM_CORES-1:0]            monitor_ready,
  input  logic [NUM_CORES-1:0]            action_ack,
  output logic [IR_W-1:0]                 ir_out,
  output logic [DR_W-1:0]                 jdo,
  output logic [NUM_CORES*(2**IR_W)-1:0]  take_action,
  output logic                            busy,
  output logic                            overrun,
  output logic                            timeout,
  output logic                            sel_err
);

  localparam int ACT_N = NUM_CORES * (2**IR_W);
  localparam int CNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM = (ACK_TIMEOUT > 0) ? CNT_W'(ACK_TIMEOUT - 1) : '0;

  typedef enum logic {IDLE, PEND} state_t;

  state_t                   state_q, state_d;
  logic [DR_W-1:0]          sr;
  logic [CSEL_W+IR_W-1:0]   ir_reg;
  logic [CSEL_W-1:0]        sel_core;
  logic [IR_W-1:0]          sel_instr;
  logic [CSEL_W-1:0]        pend_core;
  logic [CNT_W-1:0]         cnt;
  logic                     sel_valid;
  logic                     do_uir, do_udr, do_cdr, do_sdr;
  logic                     accept, finish, expire;
  logic                     ack_sel, ready_sel;
  logic [DR_W-1:0]          cap_word;
  logic [ACT_N-1:0]         act_vec;

  assign {sel_core, sel_instr} = ir_reg;
  assign sel_valid = (int'(sel_core) < NUM_CORES);

  // Only the highest-priority strobe acts: uir > udr > cdr > sdr.
  assign do_uir = vs_uir;
  assign do_udr = vs_udr & ~vs_uir;
  assign do_cdr = vs_cdr & ~vs_uir & ~vs_udr;
  assign do_sdr = vs_sdr & ~vs_uir & ~vs_udr & ~vs_cdr;

  assign tdo  = sr[0];
  assign busy = (state_q == PEND);

  // Per-core selection: capture word, ready status, one-hot action, and the
  // ack of the core that owns the outstanding request.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned; otherwise synthesis would infer a latch.
    cap_word  = '0;
    ready_sel = 1'b0;
    ack_sel   = 1'b0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (sel_valid && int'(sel_core) == k) begin
        cap_word  = capture_data[k*DR_W +: DR_W];
        ready_sel = monitor_ready[k];
      end
      if (int'(pend_core) == k) ack_sel = action_ack[k];
    end
    for (int i = 0; i < ACT_N; i++) act_vec[i] = (i == int'(ir_reg));
  end

  // Status word: bit0 ready of selected core, bit1 pending, rest zero.
  generate
    if (IR_W > 1) begin : g_ir_out_wide
      always_comb begin
        ir_out    = '0;
        ir_out[0] = ready_sel;
        ir_out[1] = busy;
      end
    end else begin : g_ir_out_narrow
      assign ir_out[0] = ready_sel;
    end
  endgenerate

  // Next-state logic: accept an update in IDLE, leave PEND on ack or timeout.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    expire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (do_udr && sel_valid) begin
          accept  = 1'b1;
          state_d = PEND;
        end
      end
      PEND: begin
        if (ack_sel) begin
          finish  = 1'b1;
          state_d = IDLE;
        end else if (ACK_TIMEOUT != 0 && cnt == CNT_TERM) begin
          expire  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Instruction register and sticky status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_reg  <= '0;
      sel_err <= 1'b0;
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (do_uir) begin
        ir_reg  <= ir_in;
        sel_err <= !(int'(ir_in[CSEL_W+IR_W-1:IR_W]) < NUM_CORES);
        overrun <= 1'b0;
      end else if (state_q == PEND && do_udr) begin
        overrun <= 1'b1;
      end
      if (expire)      timeout <= 1'b1;
      else if (do_uir) timeout <= 1'b0;
    end
  end

  // Data shift register: capture or LSB-first shift.
  always_ff @(posedge clk) begin
    if (reset)       sr <= '0;
    else if (do_cdr) sr <= cap_word;
    else if (do_sdr) sr <= {tdi, sr[DR_W-1:1]};
  end

  // Update latch, request vector and ack-timeout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      jdo         <= '0;
      take_action <= '0;
      pend_core   <= '0;
      cnt         <= '0;
    end else if (accept) begin
      jdo         <= sr;
      take_action <= act_vec;
      pend_core   <= sel_core;
      cnt         <= '0;
    end else if (finish || expire) begin
      take_action <= '0;
    end else if (state_q == PEND && cnt != '1) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_debug_slave_hub.sv
// Scoreboard bench for debug_slave_hub: the driver pushes expected tdo bits,
// status snapshots and request lifetimes into queues; a negedge monitor pops
// and compares whenever the DUT shifts, is probed, or raises/drops a request.
module tb_debug_slave_hub;

  localparam int NC = 3;
  localparam int DW = 38;
  localparam int IW = 2;
  localparam int TO = 8;
  localparam int CW = 2;
  localparam int AN = NC * 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              vs_uir = 0, vs_cdr = 0, vs_sdr = 0, vs_udr = 0;
  logic [CW+IW-1:0]  ir_in = '0;
  logic              tdi = 0;
  logic              tdo;
  logic [NC*DW-1:0]  capture_data = '0;
  logic [NC-1:0]     monitor_ready = '0;
  logic [NC-1:0]     action_ack = '0;
  logic [IW-1:0]     ir_out;
  logic [DW-1:0]     jdo;
  logic [AN-1:0]     take_action;
  logic              busy, overrun, timeout, sel_err;

  debug_slave_hub #(.NUM_CORES(NC), .DR_W(DW), .IR_W(IW), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr),
    .vs_udr(vs_udr), .ir_in(ir_in), .tdi(tdi), .tdo(tdo),
    .capture_data(capture_data), .monitor_ready(monitor_ready),
    .action_ack(action_ack), .ir_out(ir_out), .jdo(jdo),
    .take_action(take_action), .busy(busy), .overrun(overrun),
    .timeout(timeout), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AN-1:0] ta;
    logic [DW-1:0] jdo;
    int            dur;
    bit            to;
    logic [DW-1:0] jdo_after;
  } act_t;

  typedef struct {
    logic          sel_err, overrun, timeout;
    logic [IW-1:0] ir_out;
    logic [DW-1:0] jdo;
  } st_t;

  act_t act_q[$];
  st_t  st_q[$];
  bit   tdo_q[$];

  int   n_cmp = 0;
  int   n_bad = 0;
  logic probe = 1'b0;
  bit   mon_en = 1'b0;

  // Reference model: architectural state only.
  int            m_core, m_instr;
  bit            m_sel_err, m_ovr, m_to;
  logic [DW-1:0] m_jdo, m_sr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  act_t cur;
  bit   active = 0;
  int   hi_cnt = 0;
  logic [AN-1:0] prev_ta = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (vs_sdr && !vs_uir && !vs_udr && !vs_cdr) begin
        if (tdo_q.size() == 0) fail_evt("tdo_unexpected");
        else check("tdo", tdo, tdo_q.pop_front());
      end
      if (probe) begin
        if (st_q.size() == 0) fail_evt("probe_unexpected");
        else begin
          st_t s;
          s = st_q.pop_front();
          check("sel_err", sel_err, s.sel_err);
          check("overrun", overrun, s.overrun);
          check("timeout", timeout, s.timeout);
          check("ir_out", ir_out, s.ir_out);
          check("jdo_idle", jdo, s.jdo);
          check("busy_idle", busy, 0);
          check("ta_idle", take_action, 0);
        end
      end
      if (!active && prev_ta == '0 && take_action != '0) begin
        if (act_q.size() == 0) fail_evt("action_unexpected");
        else begin
          cur = act_q.pop_front();
          check("ta_rise", take_action, cur.ta);
          check("jdo_update", jdo, cur.jdo);
          check("busy_rise", busy, 1);
          active = 1;
          hi_cnt = 1;
        end
      end else if (active && take_action != '0) begin
        check("ta_hold", take_action, cur.ta);
        hi_cnt++;
      end else if (active) begin
        check("ta_duration", hi_cnt, cur.dur);
        check("timeout_end", timeout, cur.to);
        check("jdo_end", jdo, cur.jdo_after);
        check("busy_end", busy, 0);
        active = 0;
      end
      prev_ta = take_action;
    end
  end

  // ---------------- driver ----------------
  task automatic probe_status();
    st_t s;
    s.sel_err = m_sel_err;
    s.overrun = m_ovr;
    s.timeout = m_to;
    s.ir_out  = {1'b0, (m_core < NC) ? monitor_ready[m_core] : 1'b0};
    s.jdo     = m_jdo;
    st_q.push_back(s);
    ir_in = CW+IW'($urandom);  // must have no effect without vs_uir
    probe = 1'b1;
    step();
    probe = 1'b0;
  endtask

  task automatic set_ir(input int core, input int instr, input bit with_udr);
    ir_in  = {CW'(core), IW'(instr)};
    vs_uir = 1'b1;
    vs_udr = with_udr;
    step();
    vs_uir = 1'b0;
    vs_udr = 1'b0;
    m_core = core;
    m_instr = instr;
    m_ovr = 0;
    m_to = 0;
    m_sel_err = (core >= NC);
  endtask

  task automatic randomize_env();
    for (int k = 0; k < NC*DW; k++) capture_data[k] = 1'($urandom_range(0, 1));
    monitor_ready = NC'($urandom);
  endtask

  task automatic do_action(input int core, input int instr, input logic [DW-1:0] data,
                           input int ack_at, input int ovr_at, input int rst_at,
                           input bit force_cap, input logic [DW-1:0] cap);
    bit   valid, tmo, rst_hit, ovr;
    int   end_c;
    act_t a;
    randomize_env();
    if (force_cap && core < NC) capture_data[core*DW +: DW] = cap;
    valid = (core < NC);
    set_ir(core, instr, 0);
    probe_status();
    // capture
    vs_cdr = 1'b1;
    step();
    vs_cdr = 1'b0;
    m_sr = valid ? capture_data[core*DW +: DW] : '0;
    // shift: i-th tdo bit is the i-th captured bit
    for (int i = 0; i < DW; i++) begin
      tdi = data[i];
      vs_sdr = 1'b1;
      tdo_q.push_back(m_sr[i]);
      step();
    end
    vs_sdr = 1'b0;
    m_sr = data;
    // request lifetime
    tmo     = !(ack_at >= 1 && ack_at <= TO);
    end_c   = tmo ? TO : ack_at;
    rst_hit = (rst_at > 0 && rst_at <= end_c);
    if (rst_hit) begin
      end_c = rst_at;
      tmo = 0;
    end
    ovr = valid && ovr_at >= 1 && ovr_at <= end_c;
    if (valid) begin
      a.ta = AN'(1) << (core*4 + instr);
      a.jdo = data;
      a.dur = end_c;
      a.to = tmo;
      a.jdo_after = rst_hit ? '0 : data;
      act_q.push_back(a);
      m_jdo = data;
    end
    vs_udr = 1'b1;
    step();
    vs_udr = 1'b0;
    for (int c = 1; c <= TO + 2; c++) begin
      action_ack = NC'($urandom);
      if (valid) action_ack[core] = (c == ack_at);
      vs_cdr = (ovr_at >= 2 && c == ovr_at - 1);
      vs_udr = (c == ovr_at);
      reset  = (c == rst_at);
      step();
      action_ack = '0;
      vs_cdr = 0;
      vs_udr = 0;
      reset = 0;
    end
    if (rst_hit) begin
      m_core = 0; m_instr = 0; m_sel_err = 0; m_ovr = 0; m_to = 0; m_jdo = '0;
    end else begin
      m_ovr = m_ovr | ovr;
      m_to  = valid & tmo;
    end
    probe_status();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_core = 0; m_instr = 0; m_sel_err = 0; m_ovr = 0; m_to = 0;
    m_jdo = '0; m_sr = '0;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    mon_en = 1'b1;
    monitor_ready = 3'b101;
    probe_status();
    check("tdo_reset", tdo, 0);

    // core 2, instr 1 -> bit 9; ack at cycle 5 with noise on other acks
    do_action(2, 1, 38'h15_0F0F_F0F0, 5, 0, 0, 1, 38'h2A_5555_AAAA);
    // overrun while pending
    do_action(1, 3, DW'({$urandom, $urandom}), 6, 3, 0, 0, '0);
    // timeout: no ack
    do_action(0, 2, DW'({$urandom, $urandom}), 0, 0, 0, 0, '0);
    // ack on the terminal-count cycle wins
    do_action(2, 0, DW'({$urandom, $urandom}), 8, 0, 0, 0, '0);
    // minimum pend duration
    do_action(1, 1, DW'({$urandom, $urandom}), 1, 0, 0, 0, '0);
    // invalid select
    do_action(3, 2, DW'({$urandom, $urandom}), 2, 0, 0, 0, '0);
    // uir and udr together: only ir_reg changes
    set_ir(1, 0, 1);
    repeat (4) step();
    probe_status();
    // reset in PEND
    do_action(0, 3, DW'({$urandom, $urandom}), 0, 0, 3, 0, '0);

    for (int t = 0; t < 20; t++) begin
      int core, instr, ack_at, endc, ovr_at;
      core   = $urandom_range(0, 3);
      instr  = $urandom_range(0, 3);
      ack_at = $urandom_range(0, 10);
      endc   = (ack_at >= 1 && ack_at <= TO) ? ack_at : TO;
      ovr_at = ($urandom_range(0, 1) == 1) ? $urandom_range(1, endc) : 0;
      do_action(core, instr, DW'({$urandom, $urandom}), ack_at, ovr_at, 0, 0, '0);
    end

    repeat (3) step();
    check("actions_drained", act_q.size(), 0);
    check("tdo_drained", tdo_q.size(), 0);
    check("monitor_idle", active, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
